// File: rtl/regbus_pkg.sv
// Shared types and constants for the register-bus initiator.
package regbus_pkg;

    // Initiator FSM state encoding
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUS    = 2'd1,
        ST_RDWAIT = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // Largest supported responder read latency
    localparam int RDLAT_MAX = 15;

    // Width of the read-latency down counter
    localparam int CNTW = 4;

endpackage

// File: rtl/regbus_initiator.sv
// Register-bus initiator: takes one read/write command at a time, issues it
// as a single bus cycle, waits out the responder read latency and returns
// read data on a valid/ready response channel. All outputs are registered.
// Optional feature: define REGBUS_INITIATOR_WRITE_ACK_EN to make every write
// produce a response beat (o_rsp_we=1, o_rsp_rdata=0).
module regbus_initiator
    import regbus_pkg::*;
#(
    parameter int DATAW = 8,
    parameter int ADDRW = 8,
    parameter int RDLAT = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic             i_req_we,
    input  logic [ADDRW-1:0] i_req_addr,
    input  logic [DATAW-1:0] i_req_wdata,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic             o_rsp_we,
    output logic [DATAW-1:0] o_rsp_rdata,
    output logic             o_bus_we,
    output logic [ADDRW-1:0] o_bus_addr,
    output logic [DATAW-1:0] o_bus_data,
    input  logic [DATAW-1:0] i_bus_data
);

    // Read latency must fit the counter and be at least one cycle
    generate
        if (RDLAT < 1 || RDLAT > RDLAT_MAX) begin : g_bad_rdlat
            $error("regbus_initiator: RDLAT out of range 1..15");
        end
    endgenerate

    state_t          state;
    logic            cmd_we;   // type of the command in flight
    logic [CNTW-1:0] cnt;      // remaining read-latency cycles

    // Command FSM; every output is a flop updated here
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= ST_IDLE;
            cmd_we      <= 1'b0;
            cnt         <= '0;
            o_req_ready <= 1'b0;
            o_rsp_valid <= 1'b0;
            o_rsp_we    <= 1'b0;
            o_rsp_rdata <= '0;
            o_bus_we    <= 1'b0;
            o_bus_addr  <= '0;
            o_bus_data  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (o_req_ready && i_req_valid) begin
                        o_req_ready <= 1'b0;
                        o_bus_addr  <= i_req_addr;
                        o_bus_data  <= i_req_wdata;
                        o_bus_we    <= i_req_we;
                        cmd_we      <= i_req_we;
                        state       <= ST_BUS;
                    end else begin
                        // first cycle after reset raises ready here
                        o_req_ready <= 1'b1;
                    end
                end
                ST_BUS: begin
                    // write strobe lasts exactly this address cycle
                    o_bus_we <= 1'b0;
                    if (cmd_we) begin
`ifdef REGBUS_INITIATOR_WRITE_ACK_EN
                        o_rsp_valid <= 1'b1;
                        o_rsp_we    <= 1'b1;
                        o_rsp_rdata <= '0;
                        state       <= ST_RESP;
`else
                        o_req_ready <= 1'b1;
                        state       <= ST_IDLE;
`endif
                    end else begin
                        cnt   <= CNTW'(RDLAT - 1);
                        state <= ST_RDWAIT;
                    end
                end
                ST_RDWAIT: begin
                    if (cnt == '0) begin
                        o_rsp_rdata <= i_bus_data;
                        o_rsp_we    <= 1'b0;
                        o_rsp_valid <= 1'b1;
                        state       <= ST_RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    // response fields stay frozen until consumed
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        o_req_ready <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regbus_initiator.sv
// Self-checking bench for regbus_initiator: directed cases plus randomized
// read/write traffic against a five-register responder and a reference
// register image. A second instance uses RDLAT=3.
module tb_regbus_initiator;

    localparam int DW  = 8;
    localparam int AW  = 8;
    localparam int RL  = 1;
    localparam int RL3 = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // main instance signals
    logic          req_valid = 1'b0, req_ready, req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid, rsp_ready = 1'b0, rsp_we;
    logic [DW-1:0] rsp_rdata;
    logic          bus_we;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_data, bus_rdata;

    // RDLAT=3 instance signals
    logic          req_valid3 = 1'b0, req_ready3;
    logic          rsp_valid3, rsp_ready3 = 1'b0, rsp_we3;
    logic [DW-1:0] rsp_rdata3;
    logic          bus_we3;
    logic [AW-1:0] bus_addr3;
    logic [DW-1:0] bus_data3, bus_rdata3;

    regbus_initiator #(.DATAW(DW), .ADDRW(AW), .RDLAT(RL)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_we(rsp_we),
        .o_rsp_rdata(rsp_rdata),
        .o_bus_we(bus_we), .o_bus_addr(bus_addr), .o_bus_data(bus_data),
        .i_bus_data(bus_rdata)
    );

    regbus_initiator #(.DATAW(DW), .ADDRW(AW), .RDLAT(RL3)) u_dut3 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid3), .o_req_ready(req_ready3), .i_req_we(1'b0),
        .i_req_addr(8'd0), .i_req_wdata(8'd0),
        .o_rsp_valid(rsp_valid3), .i_rsp_ready(rsp_ready3), .o_rsp_we(rsp_we3),
        .o_rsp_rdata(rsp_rdata3),
        .o_bus_we(bus_we3), .o_bus_addr(bus_addr3), .o_bus_data(bus_data3),
        .i_bus_data(bus_rdata3)
    );

    // five-register responder, one-cycle registered read
    logic [DW-1:0] rmem [5] = '{default: 8'h00};
    always @(posedge clk) begin
        if (bus_we && bus_addr < 5) rmem[bus_addr[2:0]] <= bus_data;
        bus_rdata <= (bus_addr < 5) ? rmem[bus_addr[2:0]] : 8'h00;
    end

    // read-only responder with a three-stage read pipeline
    logic [DW-1:0] rmem3 [5] = '{8'h3C, 8'h01, 8'h02, 8'h03, 8'h04};
    logic [DW-1:0] p3 [3] = '{default: 8'h00};
    always @(posedge clk) begin
        p3[0] <= (bus_addr3 < 5) ? rmem3[bus_addr3[2:0]] : 8'h00;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign bus_rdata3 = p3[2];

    // reference register image
    logic [DW-1:0] ref_mem [5] = '{default: 8'h00};
    int  checks = 0;
    int  errors = 0;
    bit  tie_ready = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic accept(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        int n = 0;
        while (req_ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("req_ready_wait", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = data;
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = 1'b0;
        req_addr = 8'($urandom); req_wdata = 8'($urandom);
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        accept(1'b1, addr, data);
        chk("wr_bus_we", {31'b0, bus_we}, 32'd1);
        chk("wr_bus_addr", {24'b0, bus_addr}, {24'b0, addr});
        chk("wr_bus_data", {24'b0, bus_data}, {24'b0, data});
        chk("wr_busy", {31'b0, req_ready}, 32'd0);
        if (addr < 5) ref_mem[addr[2:0]] = data;
        @(posedge clk); #1;
        chk("wr_bus_we_drop", {31'b0, bus_we}, 32'd0);
`ifdef REGBUS_INITIATOR_WRITE_ACK_EN
        chk("wr_ack_valid", {31'b0, rsp_valid}, 32'd1);
        chk("wr_ack_we", {31'b0, rsp_we}, 32'd1);
        chk("wr_ack_rdata", {24'b0, rsp_rdata}, 32'd0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = tie_ready;
        chk("wr_ack_retire", {31'b0, rsp_valid}, 32'd0);
        chk("wr_ack_ready", {31'b0, req_ready}, 32'd1);
`else
        chk("wr_ready_back", {31'b0, req_ready}, 32'd1);
        chk("wr_no_rsp", {31'b0, rsp_valid}, 32'd0);
`endif
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input int stall);
        logic [DW-1:0] exp;
        int n = 0;
        exp = (addr < 5) ? ref_mem[addr[2:0]] : 8'h00;
        accept(1'b0, addr, 8'($urandom));
        chk("rd_bus_we", {31'b0, bus_we}, 32'd0);
        chk("rd_bus_addr", {24'b0, bus_addr}, {24'b0, addr});
        while (rsp_valid !== 1'b1 && n < 40) begin
            chk("rd_busy", {31'b0, req_ready}, 32'd0);
            @(posedge clk); #1; n++;
        end
        // edges after the accept edge until valid is visible
        chk("rd_latency", n, RL + 1);
        for (int s = 0; s < stall; s++) begin
            chk("rd_stall_valid", {31'b0, rsp_valid}, 32'd1);
            chk("rd_stall_rdata", {24'b0, rsp_rdata}, {24'b0, exp});
            chk("rd_stall_busy", {31'b0, req_ready}, 32'd0);
            @(posedge clk); #1;
        end
        chk("rd_valid", {31'b0, rsp_valid}, 32'd1);
        chk("rd_rdata", {24'b0, rsp_rdata}, {24'b0, exp});
        chk("rd_we", {31'b0, rsp_we}, 32'd0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = tie_ready;
        chk("rd_retire", {31'b0, rsp_valid}, 32'd0);
        chk("rd_ready_back", {31'b0, req_ready}, 32'd1);
    endtask

    initial begin
        // reset values while held
        #2;
        chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rsp_we", {31'b0, rsp_we}, 32'd0);
        chk("rst_rsp_rdata", {24'b0, rsp_rdata}, 32'd0);
        chk("rst_bus_we", {31'b0, bus_we}, 32'd0);
        chk("rst_bus_addr", {24'b0, bus_addr}, 32'd0);
        chk("rst_bus_data", {24'b0, bus_data}, 32'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", {31'b0, req_ready}, 32'd1);

        // write then read back
        do_write(8'd2, 8'hA5);
        do_read(8'd2, 0);

        // fill all registers, then reads with response ready tied high
        for (int i = 0; i < 5; i++) do_write(8'(i), 8'(8'h11 * (i + 1)));
        tie_ready = 1'b1; rsp_ready = 1'b1;
        do_read(8'd4, 0);
        do_read(8'd0, 0);
        do_read(8'd3, 0);
        tie_ready = 1'b0; rsp_ready = 1'b0;

        // response stalled five cycles
        do_read(8'd1, 5);

        // reset during the read-wait cycle
        accept(1'b0, 8'd1, 8'h00);
        @(posedge clk); #1;
        rst_n = 1'b0; #1;
        chk("abort_req_ready", {31'b0, req_ready}, 32'd0);
        chk("abort_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("abort_rsp_rdata", {24'b0, rsp_rdata}, 32'd0);
        chk("abort_bus_addr", {24'b0, bus_addr}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_ready_back", {31'b0, req_ready}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("abort_no_rsp", {31'b0, rsp_valid}, 32'd0);
            @(posedge clk); #1;
        end

        // reset during a write address cycle drops the strobe at once
        accept(1'b1, 8'd2, 8'hEE);
        chk("abort_wr_we_pre", {31'b0, bus_we}, 32'd1);
        rst_n = 1'b0; #1;
        chk("abort_wr_we", {31'b0, bus_we}, 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // single write whose response depends on the ack build option
        do_write(8'd3, 8'h7E);
        do_read(8'd3, 0);

        // randomized mixed traffic
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1)
                do_write(8'($urandom_range(0, 4)), 8'($urandom));
            else
                do_read(8'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
        end

        // RDLAT=3 instance: read addr 0
        begin
            int n = 0;
            chk("rl3_ready", {31'b0, req_ready3}, 32'd1);
            req_valid3 = 1'b1;
            @(posedge clk); #1;
            req_valid3 = 1'b0;
            while (rsp_valid3 !== 1'b1 && n < 40) begin
                @(posedge clk); #1; n++;
            end
            chk("rl3_latency", n, RL3 + 1);
            chk("rl3_rdata", {24'b0, rsp_rdata3}, 32'h3C);
            chk("rl3_we", {31'b0, rsp_we3}, 32'd0);
            rsp_ready3 = 1'b1;
            @(posedge clk); #1;
            rsp_ready3 = 1'b0;
            chk("rl3_retire", {31'b0, rsp_valid3}, 32'd0);
            chk("rl3_ready_back", {31'b0, req_ready3}, 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
